// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - display, host and frame-RAM bus bundle for vram_arbiter
// slave = arbiter side, master = the agents and memory that surround it.
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;

  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              host_starve;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    output disp_rdata, disp_rvalid, host_ready, host_rdata, host_rvalid, host_starve,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    input  disp_rdata, disp_rvalid, host_ready, host_rdata, host_rvalid, host_starve,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port frame RAM arbiter, display fetch over host port
// Define VRAM_ARB_FRAME_LOCK_EN to restrict host accesses to vertical blanking.
module vram_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 24,
  parameter int MAX_WAIT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           DE,
  input  logic           EndFrame,
  vram_arbiter_if.slave  bus
);

  typedef enum logic {ST_VBLANK = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        d_pend_q, d_pend_d;
  logic        h_pend_q, h_pend_d;
  logic        starve_q, starve_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        host_window;
  logic        gnt_d, gnt_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_VBLANK;
      d_pend_q   <= 1'b0;
      h_pend_q   <= 1'b0;
      starve_q   <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      d_pend_q   <= d_pend_d;
      h_pend_q   <= h_pend_d;
      starve_q   <= starve_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (EndFrame) begin
      state_d = ST_VBLANK;
    end else if (state_q == ST_VBLANK && DE) begin
      state_d = ST_ACTIVE;
    end
  end

`ifdef VRAM_ARB_FRAME_LOCK_EN
  assign host_window = (state_q == ST_VBLANK);
`else
  assign host_window = 1'b1;
`endif

  // Grants are masked during reset so every output reads 0 while reset is held.
  always_comb begin
    gnt_d = bus.disp_req & ~reset;
    gnt_h = bus.host_valid & ~bus.disp_req & host_window & ~reset;

    bus.host_ready = gnt_h;
    bus.mem_en     = gnt_d | gnt_h;
    bus.mem_we     = gnt_h & bus.host_we;
    bus.mem_addr   = gnt_d ? bus.disp_addr : (gnt_h ? bus.host_addr : '0);
    bus.mem_wdata  = (gnt_d | gnt_h) ? bus.host_wdata : '0;

    d_pend_d = gnt_d;
    h_pend_d = gnt_h & ~bus.host_we;

    wait_cnt_d = '0;
    if (bus.host_valid && !gnt_h) begin
      wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
    end
    starve_d = (wait_cnt_d >= 16'(MAX_WAIT));

    // Pending reads are suppressed in the reset cycle itself, not just after it.
    bus.disp_rvalid = d_pend_q & ~reset;
    bus.host_rvalid = h_pend_q & ~reset;
    bus.disp_rdata  = bus.disp_rvalid ? bus.mem_rdata : '0;
    bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : '0;
    bus.host_starve = starve_q & ~reset;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic reset;
  logic DE;
  logic EndFrame;
  int   checks = 0;
  int   failures = 0;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .DE       (DE),
    .EndFrame (EndFrame),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame RAM: one address returns a fixed pattern, others echo the address.
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= (bus.mem_addr == 19'h4B000) ? 24'hA5C3E1 : {5'h0, bus.mem_addr};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    DE = 0; EndFrame = 0;
    bus.disp_req = 0; bus.disp_addr = '0;
    bus.host_valid = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1; DE = 0; EndFrame = 0;
    bus.disp_req = 1; bus.disp_addr = 19'h00123;
    bus.host_valid = 1; bus.host_we = 0; bus.host_addr = 19'h00055; bus.host_wdata = 24'h111111;
    bus.mem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.host_ready, bus.disp_rvalid, bus.host_rvalid, bus.host_starve} !== 6'b0
          || bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.disp_rdata !== '0 || bus.host_rdata !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d en=%b we=%b rdy=%b drv=%b hrv=%b stv=%b addr=%h required all 0",
                 c, bus.mem_en, bus.mem_we, bus.host_ready, bus.disp_rvalid, bus.host_rvalid, bus.host_starve, bus.mem_addr);
      end
      step();
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 19'h00123 || bus.host_ready !== 1'b0 || bus.disp_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release en=%b addr=%h rdy=%b drv=%b required 1 00123 0 0",
               bus.mem_en, bus.mem_addr, bus.host_ready, bus.disp_rvalid);
    end
    step(); idle(); step();
  endtask

  task automatic test_priority();
    bus.host_valid = 1; bus.host_we = 1; bus.host_addr = 19'h00010; bus.host_wdata = 24'h123456;
    for (int c = 1; c <= 7; c++) begin
      bus.disp_req  = (c <= 5);
      bus.disp_addr = 19'(32'h100 + c);
      bus.host_valid = (c <= 6);
      @(negedge clk);
      checks++;
      if (bus.host_ready !== (c == 6)) begin
        failures++;
        $display("FAIL prio_ready cyc=%0d got=%b required=%b", c, bus.host_ready, (c == 6));
      end
      checks++;
      if (bus.disp_rvalid !== (c >= 2 && c <= 6)) begin
        failures++;
        $display("FAIL prio_disp_rvalid cyc=%0d got=%b required=%b", c, bus.disp_rvalid, (c >= 2 && c <= 6));
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (bus.disp_rdata !== 24'(32'h100 + c - 1)) begin
          failures++;
          $display("FAIL prio_disp_rdata cyc=%0d got=%h required=%h", c, bus.disp_rdata, 24'(32'h100 + c - 1));
        end
      end
      if (c <= 5) begin
        checks++;
        if (bus.mem_addr !== 19'(32'h100 + c) || bus.mem_we !== 1'b0) begin
          failures++;
          $display("FAIL prio_disp_addr cyc=%0d addr=%h we=%b required=%h 0", c, bus.mem_addr, bus.mem_we, 19'(32'h100 + c));
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'h00010 || bus.mem_wdata !== 24'h123456) begin
          failures++;
          $display("FAIL prio_host_write we=%b addr=%h wdata=%h required 1 00010 123456",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      step();
    end
    idle(); step();
  endtask

  task automatic test_read_return();
    bus.host_valid = 1; bus.host_we = 0; bus.host_addr = 19'h4B000;
    @(negedge clk);
    checks++;
    if (bus.host_ready !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 19'h4B000) begin
      failures++;
      $display("FAIL rd_grant rdy=%b en=%b we=%b addr=%h required 1 1 0 4b000",
               bus.host_ready, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 24'hA5C3E1 || bus.disp_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_return hrv=%b hrdata=%h drv=%b required 1 a5c3e1 0",
               bus.host_rvalid, bus.host_rdata, bus.disp_rvalid);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== '0) begin
      failures++;
      $display("FAIL rd_after hrv=%b hrdata=%h required 0 0", bus.host_rvalid, bus.host_rdata);
    end
    step();
  endtask

  task automatic test_frame_lock();
    int g;
`ifdef VRAM_ARB_FRAME_LOCK_EN
    g = 10;
`else
    g = 4;
`endif
    bus.host_we = 1; bus.host_addr = 19'h00020; bus.host_wdata = 24'h0F0F0F;
    for (int c = 1; c <= 11; c++) begin
      DE           = (c <= 3) || (c >= 6 && c <= 8);
      bus.disp_req = DE;
      EndFrame     = (c == 9);
      bus.host_valid = (c <= g);
      @(negedge clk);
      checks++;
      if (bus.host_ready !== (c == g)) begin
        failures++;
        $display("FAIL frame_ready cyc=%0d got=%b required=%b", c, bus.host_ready, (c == g));
      end
      step();
    end
    idle(); step();
  endtask

  task automatic test_starve();
    bus.host_we = 1; bus.host_addr = 19'h00030; bus.host_wdata = 24'h333333;
    for (int c = 1; c <= 7; c++) begin
      bus.disp_req   = (c <= 5);
      bus.host_valid = (c <= 6);
      @(negedge clk);
      checks++;
      if (bus.host_starve !== (c >= 5 && c <= 6)) begin
        failures++;
        $display("FAIL starve cyc=%0d got=%b required=%b", c, bus.host_starve, (c >= 5 && c <= 6));
      end
      checks++;
      if (bus.host_ready !== (c == 6)) begin
        failures++;
        $display("FAIL starve_ready cyc=%0d got=%b required=%b", c, bus.host_ready, (c == 6));
      end
      step();
    end
    idle(); step();
  endtask

  task automatic test_simultaneous();
    DE = 1; bus.disp_req = 1; bus.disp_addr = 19'h00200;
    step();
    EndFrame = 1;
    step();
    idle();
    bus.host_valid = 1; bus.host_we = 1; bus.host_addr = 19'h00040; bus.host_wdata = 24'h444444;
    @(negedge clk);
    checks++;
    if (bus.host_ready !== 1'b1 || bus.mem_addr !== 19'h00040) begin
      failures++;
      $display("FAIL simul_grant rdy=%b addr=%h required 1 00040", bus.host_ready, bus.mem_addr);
    end
    step(); idle(); step();
  endtask

  task automatic test_reset_mid();
    bus.disp_req = 1; bus.disp_addr = 19'h00300;
    step();
    bus.disp_req = 0; reset = 1;
    @(negedge clk);
    checks++;
    if (bus.disp_rvalid !== 1'b0 || bus.disp_rdata !== '0) begin
      failures++;
      $display("FAIL mid_reset_in drv=%b rdata=%h required 0 0", bus.disp_rvalid, bus.disp_rdata);
    end
    step();
    reset = 0;
    @(negedge clk);
    checks++;
    if (bus.disp_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_after drv=%b hrv=%b required 0 0", bus.disp_rvalid, bus.host_rvalid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_read_return();
    test_frame_lock();
    test_starve();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-memory arbiter between the HDMI pixel fetch path and a host read/write port. Sits between the sync generator and pixel pipeline of `IPCore` and one synchronous-read frame RAM (BRAM, 1-cycle read latency).
- Display fetch has absolute priority, so active-video pixels are never delayed.
- Host accesses use the remaining cycles, gated by a frame-phase state machine driven by `DE` and `EndFrame`.
- Host starvation is reported to the rest of the system.

## Interface
Parameters:
- `ADDR_W`, 19, memory word address width (640x480 = 307200 words).
- `DATA_W`, 24, word width ({red, green, blue}, 8 bits each).
- `MAX_WAIT`, 1024, number of consecutive host wait cycles at which `host_starve` asserts; legal range 1..65535.

Ports:
- `clk` in 1: pixel clock. One clock domain for the whole block.
- `reset` in 1: synchronous, active-high.
- `DE` in 1: data-enable from the sync generator.
- `EndFrame` in 1: single-cycle pulse on the last cycle of a frame.
- `disp_req` in 1: display read request, one word per cycle.
- `disp_addr` in ADDR_W: display read address.
- `disp_rdata` out DATA_W: display read data.
- `disp_rvalid` out 1: `disp_rdata` valid.
- `host_valid` in 1: host request pending.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_ready` out 1: host request accepted this cycle.
- `host_rdata` out DATA_W: host read data.
- `host_rvalid` out 1: `host_rdata` valid.
- `host_starve` out 1: host has waited at least `MAX_WAIT` cycles.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid 1 cycle after a read.

## Operation
Frame-phase FSM, two states:
- `ST_VBLANK`: entered on reset and on any cycle with `EndFrame`=1.
  - Moves to `ST_ACTIVE` on the first cycle with `DE`=1 and `EndFrame`=0.
- `ST_ACTIVE`: stays until `EndFrame`=1.
  - If `EndFrame` and `DE` are both 1 in the same cycle, the next state is `ST_VBLANK`.

Grant logic (combinational, same cycle as the request):
- Display grant: `gnt_d = disp_req`. Display is never refused.
- Host grant: `gnt_h = host_valid & ~disp_req & host_window`.
  - `host_window` is defined under Configuration.
- `host_ready = gnt_h`.
- When `disp_req` and `host_valid` are both 1, display wins; the host holds its request. Valid/ready rule: `host_addr`, `host_we` and `host_wdata` must stay stable while `host_valid`=1 and `host_ready`=0.

Memory port:
- `mem_en = gnt_d | gnt_h`.
- `mem_we = gnt_h & host_we`.
- `mem_addr` = `disp_addr` if `gnt_d`, else `host_addr`.
- `mem_wdata = host_wdata`.
- All memory outputs are 0 when there is no grant.

Read return:
- The grant type is registered: `d_pend <= gnt_d`, `h_pend <= gnt_h & ~host_we`.
- `disp_rvalid = d_pend`, `host_rvalid = h_pend`.
- Both `rdata` outputs are `mem_rdata` qualified by the corresponding valid; each is 0 when its valid is 0.

Starvation counter:
- 16-bit `wait_cnt`.
  - Increments, saturating at 65535, on cycles with `host_valid`=1 and `host_ready`=0.
  - Clears on `host_ready`=1, or when `host_valid`=0.
- `host_starve` is registered: 1 when `wait_cnt` >= `MAX_WAIT`. It clears on the cycle after the grant.

## Timing
- Reset values: every output 0. FSM in `ST_VBLANK`; `d_pend`, `h_pend` and `wait_cnt` are 0.
- Reset mid-operation: a read already issued does not produce an `rvalid` after reset.
- Grant latency: 0 cycles.
- Read data latency: 1 cycle after grant, for both display and host.
- Writes complete in the grant cycle; no response is returned.
- Host throughput: one access per cycle while granted; back-to-back grants are legal.
- `host_starve` asserts on the cycle after `wait_cnt` reaches `MAX_WAIT`.

## Configuration
- `VRAM_ARB_FRAME_LOCK_EN` defined:
  - `host_window = (state == ST_VBLANK)`.
  - The host is only served during vertical blanking, which gives tear-free updates.
  - Host requests made in `ST_ACTIVE` wait (and count toward starvation) until after `EndFrame`.
- Not defined:
  - `host_window = 1`.
  - The host is served on any cycle with `disp_req`=0, including horizontal blanking.
  - The FSM is still implemented but does not gate grants.

## Test plan
- Reset behaviour: hold `reset` 3 cycles with `host_valid`=1 and `disp_req`=1 → all outputs 0. On the first cycle after release, `mem_en`=1, `mem_addr`=`disp_addr`, `host_ready`=0.
- Display priority: `disp_req`=1 and `host_valid`=1 (write to 0x00010) for 5 cycles, then `disp_req`=0 → `host_ready`=1 only on cycle 6. `mem_we`=1 with `mem_addr`=0x00010 on that cycle. `disp_rvalid`=1 on cycles 2–6.
- Read return: host read of 0x4B000 in a free cycle with the memory model returning 0xA5C3E1 → `host_rvalid`=1 and `host_rdata`=0xA5C3E1 exactly one cycle later, `disp_rvalid`=0.
- Frame lock (macro defined): host write requested during `ST_ACTIVE` with `DE` toggling per line → no grant until the cycle after `EndFrame`, then `host_ready`=1 with `disp_req`=0. Without the macro, the same stimulus is granted in the first `DE`=0 cycle.
- Starvation: `MAX_WAIT`=4 with `disp_req` held at 1 → `host_starve`=1 on the 5th wait cycle. Drop `disp_req` → grant, and `host_starve`=0 on the next cycle.
- Simultaneous events: `EndFrame`=1 and `DE`=1 in the same cycle → FSM enters `ST_VBLANK` on the next cycle. With the macro, a host request in that next cycle (`disp_req`=0) is granted.
